int_scheduler: RTL

//   Priority interrupt scheduler for the pipelined core. It captures external interrupt

---
 rtl/int_scheduler_if.sv | 27 ++
 rtl/int_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/int_scheduler_if.sv
// Control-path handshake between the interrupt scheduler and the pipeline.
//   int_req    scheduler -> pipeline   interrupt entry requested
//   int_id     scheduler -> pipeline   source being requested, stable while int_req=1
//   int_vector scheduler -> pipeline   handler address for int_id
//   int_enter  scheduler -> pipeline   one-cycle pulse after the ack: redirect PC, save EPC
//   int_ack    pipeline -> scheduler   pipeline accepts int_req this cycle
//   eret       pipeline -> scheduler   handler return retired this cycle
interface int_scheduler_if #(
  parameter int ID_W = 2
);
  logic            int_req;
  logic [ID_W-1:0] int_id;
  logic [31:0]     int_vector;
  logic            int_enter;
  logic            int_ack;
  logic            eret;

  modport master (
    output int_req, int_id, int_vector, int_enter,
    input  int_ack, eret
  );

  modport slave (
    input  int_req, int_id, int_vector, int_enter,
    output int_ack, eret
  );
endinterface

// File: rtl/int_scheduler.sv
// Priority interrupt scheduler with nested preemption.
// Captures rising edges on irq_in, arbitrates eligible sources by fixed priority
// (highest index wins), handshakes one entry at a time with the pipeline and tracks
// in-service levels until the matching eret.
//   clk, rst      system clock, synchronous active-high reset
//   irq_in        synchronised level interrupt lines
//   mask_w_*      mask register write port (1 = source enabled)
//   ie_w_*        global interrupt enable write port
//   ctl           handshake with the control path (int_req/int_id/int_vector/int_enter,
//                 int_ack/eret)
//   pending       latched, not yet serviced requests
//   irs, inting   in-service bits and their OR
//   mask, ie      current configuration
//
// state | meaning
// IDLE  | no request outstanding; pick winner when anything is eligible
// REQ   | int_req high with frozen int_id; wait for ack or withdraw
// ENTER | one-cycle int_enter pulse with valid int_vector
module int_scheduler #(
  parameter int          N_SRC      = 3,
  parameter int          ID_W       = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_4000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    irq_in,
  input  logic                mask_w_en,
  input  logic [N_SRC-1:0]    mask_w_data,
  input  logic                ie_w_en,
  input  logic                ie_w_data,
  int_scheduler_if.master     ctl,
  output logic [N_SRC-1:0]    pending,
  output logic [N_SRC-1:0]    irs,
  output logic                inting,
  output logic [N_SRC-1:0]    mask,
  output logic                ie
);

  typedef enum logic [1:0] {IDLE, REQ, ENTER} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   int_id_q, int_id_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  irs_q, irs_d;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic              ie_q, ie_d;
  logic [N_SRC-1:0]  irq_prev_q, irq_prev_d;

  logic [N_SRC-1:0]  rise;
  logic [N_SRC-1:0]  above_top;
  logic [N_SRC-1:0]  elig;
  logic [ID_W-1:0]   winner;
  logic [N_SRC-1:0]  top_oh;
  logic [N_SRC-1:0]  clr;
  logic [N_SRC-1:0]  irs_set;
  logic [N_SRC-1:0]  irs_clr;

  always_comb begin
    rise = irq_in & ~irq_prev_q;

    // Source i may preempt only if no in-service bit sits at index i or above,
    // i.e. i > top(irs) with top = -1 when nothing is in service.
    above_top = '0;
    for (int i = 0; i < N_SRC; i++) begin
      above_top[i] = 1'b1;
      for (int j = i; j < N_SRC; j++) begin
        if (irs_q[j]) above_top[i] = 1'b0;
      end
    end

    elig = pending_q & mask_q & {N_SRC{ie_q}} & above_top;

    winner = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (elig[i]) winner = ID_W'(i);
    end

    top_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (irs_q[i]) begin
        top_oh    = '0;
        top_oh[i] = 1'b1;
      end
    end

    state_d  = state_q;
    int_id_d = int_id_q;
    clr      = '0;
    irs_set  = '0;

    case (state_q)
      IDLE: begin
        if (|elig) begin
          int_id_d = winner;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (ctl.int_ack) begin
          irs_set[int_id_q] = 1'b1;
          clr[int_id_q]     = 1'b1;
          state_d           = ENTER;
        end else if (!elig[int_id_q]) begin
          state_d = IDLE;
        end
      end
      ENTER:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // eret clear goes first, then the ack set; the acked id is always above the
    // old top so the two never touch the same bit.
    irs_clr    = ctl.eret ? top_oh : '0;
    irs_d      = (irs_q & ~irs_clr) | irs_set;
    pending_d  = (pending_q & ~clr) | rise;
    mask_d     = mask_w_en ? mask_w_data : mask_q;
    ie_d       = ie_w_en ? ie_w_data : ie_q;
    irq_prev_d = irq_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      int_id_q   <= '0;
      pending_q  <= '0;
      irs_q      <= '0;
      mask_q     <= '0;
      ie_q       <= 1'b0;
      irq_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      int_id_q   <= int_id_d;
      pending_q  <= pending_d;
      irs_q      <= irs_d;
      mask_q     <= mask_d;
      ie_q       <= ie_d;
      irq_prev_q <= irq_prev_d;
    end
  end

  assign ctl.int_req    = (state_q == REQ);
  assign ctl.int_id     = int_id_q;
  assign ctl.int_enter  = (state_q == ENTER);
  assign ctl.int_vector = VEC_BASE + 32'(int_id_q) * VEC_STRIDE;

  assign pending = pending_q;
  assign irs     = irs_q;
  assign inting  = |irs_q;
  assign mask    = mask_q;
  assign ie      = ie_q;

endmodule
